radix_4_quot_otfc: RTL and testbench
====================================

// Module: radix_4_quot_otfc
// PURPOSE
//  On-the-fly quotient converter for the radix-4 SRT divider. It takes the stage just
//  downstream of the radix-4 sign coder and consumes its one-hot quotient digit
//  {+2,+1,0,-1,-2} once per iteration.
//  Keeps Q and QM = Q-1 (mod 2^QUOT_W) registers, so no final carry-propagate add.
//  Counts iterations and presents the finished quotient with a one-cycle done pulse.
// PARAMETERS
//  QUOT_W   32          quotient width in bits; must be even and >= 4
//  ITER_N   QUOT_W/2    number of radix-4 digits accumulated per division
// PORTS
//  clk         in   1        clock; all state changes on rising edge
//  rst         in   1        synchronous reset, active-high
//  start_i     in   1        begin a new division; clears Q/QM and the counter
//  flush_i     in   1        abort the current division; return to IDLE without done
//  dig_vld_i   in   1        quot_dig_i is valid this cycle
//  quot_dig_i  in   5        one-hot digit: [0]=-2 [1]=-1 [2]=0 [3]=+1 [4]=+2
//  busy_o      in/out:out 1  high while in ITER state
//  done_o      out  1        one-cycle pulse when the last digit has been absorbed
//  quot_o      out  QUOT_W   Q register: quotient, valid from done_o onward
//  quot_m1_o   out  QUOT_W   QM register: Q-1 mod 2^QUOT_W, used for remainder-sign fixup
//  dig_err_o   out  1        sticky; set when a non-one-hot digit is accepted
// BEHAVIOUR
//  Reset: state=IDLE, Q=0, QM=0, cnt=0, busy_o=0, done_o=0, dig_err_o=0.
//  States:
//   IDLE -> ITER on start_i.
//   ITER -> DONE when the ITER_N-th digit is accepted.
//   DONE -> IDLE after exactly one cycle.
//  start_i, in any state:
//   - Q<=0, QM<=all ones (-1), cnt<=0, dig_err_o<=0.
//   - Next state is ITER.
//   - Wins over flush_i and over dig_vld_i in the same cycle; that digit is dropped.
//  flush_i, without start_i:
//   - state<=IDLE and cnt<=0.
//   - Q and QM hold; no done_o.
//  dig_vld_i is ignored outside ITER.
//  In ITER with dig_vld_i, the register update (<< is a 2-bit shift, upper bits dropped):
//   +2: Q<={Q,2'b10}  QM<={Q,2'b01}
//   +1: Q<={Q,2'b01}  QM<={Q,2'b00}
//    0: Q<={Q,2'b00}  QM<={QM,2'b11}
//   -1: Q<={QM,2'b11} QM<={QM,2'b10}
//   -2: Q<={QM,2'b10} QM<={QM,2'b01}
//  Counter: cnt increments on each accepted digit.
//  Illegal digit (zero or multiple bits set):
//   - Treated as digit 0.
//   - dig_err_o<=1; it stays set until reset or start_i.
//   - cnt still increments.
//  Done timing:
//   - The digit with cnt==ITER_N-1 moves the state to DONE.
//   - done_o=1 in the cycle after that digit edge; busy_o=0 in that cycle.
//  Output hold: quot_o and quot_m1_o hold their values from DONE until the next start_i.
//  Latency: start_i to done_o is ITER_N+1 cycles minimum (one digit per cycle); stalls
//   (dig_vld_i=0) extend it.
//  Invariant: QM==Q-1 mod 2^QUOT_W after every accepted digit. There is no other
//   arithmetic; the registers wrap modulo 2^QUOT_W.
//  All outputs are registered; no combinational input-to-output path.
// TESTING (QUOT_W=8, ITER_N=4)
//  1 start; digits +2,+1,0,-1 on consecutive cycles.
//    -> quot_o=8'h8F, quot_m1_o=8'h8E; done_o pulses one cycle, 5 cycles after start.
//  2 start; four -2 digits, with dig_vld_i low for 2 cycles between the 2nd and 3rd.
//    -> quot_o=8'h56, quot_m1_o=8'h55; done_o is delayed by 2 cycles.
//  3 start; four +2 digits.
//    -> quot_o=8'hAA, quot_m1_o=8'hA9.
//  4 flush_i after 2 digits, then start_i + four 0 digits.
//    -> first run gives no done_o; second run gives quot_o=8'h00, quot_m1_o=8'hFF.
//  5 Digit 5'b01100 accepted mid-run.
//    -> dig_err_o=1 until the next start_i; treated as 0; done still after 4 digits.
//  6 rst asserted mid-ITER, and start_i together with dig_vld_i.
//    -> rst: all outputs 0 next cycle; start_i wins: digit dropped, cnt=0.

Source files
------------

// File: rtl/radix_4_quot_otfc_if.sv
// ----------------------------------------------------------------------------
// radix_4_quot_otfc_if
// Bundles the control, digit and result signals of the on-the-fly quotient
// converter. Signal suffixes are from the converter's point of view.
//   start_i    : begin a new division (clears Q/QM and the digit counter)
//   flush_i    : abort the current division, no done pulse
//   dig_vld_i  : quot_dig_i carries a digit this cycle
//   quot_dig_i : one-hot digit [0]=-2 [1]=-1 [2]=0 [3]=+1 [4]=+2
//   busy_o     : converter is accumulating digits
//   done_o     : one-cycle pulse after the last digit has been absorbed
//   quot_o     : Q register
//   quot_m1_o  : QM register (Q-1 mod 2^QUOT_W)
//   dig_err_o  : sticky flag, a non-one-hot digit was accepted
// master: the digit producer / controller.  slave: the converter.
// ----------------------------------------------------------------------------
interface radix_4_quot_otfc_if #(
   parameter int QUOT_W = 32
);
   logic              start_i;
   logic              flush_i;
   logic              dig_vld_i;
   logic [4:0]        quot_dig_i;
   logic              busy_o;
   logic              done_o;
   logic [QUOT_W-1:0] quot_o;
   logic [QUOT_W-1:0] quot_m1_o;
   logic              dig_err_o;

   modport master (
      output start_i, flush_i, dig_vld_i, quot_dig_i,
      input  busy_o, done_o, quot_o, quot_m1_o, dig_err_o
   );

   modport slave (
      input  start_i, flush_i, dig_vld_i, quot_dig_i,
      output busy_o, done_o, quot_o, quot_m1_o, dig_err_o
   );
endinterface

// File: rtl/radix_4_quot_otfc.sv
// ----------------------------------------------------------------------------
// radix_4_quot_otfc
// On-the-fly quotient converter for a radix-4 SRT divider. Each accepted
// digit d in {-2..+2} performs Q <= 4*Q + d while QM tracks Q-1, so the final
// quotient needs no carry-propagate adder: negative digits borrow by taking
// their upper bits from QM instead of Q.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous reset, active-high
//   bus  : radix_4_quot_otfc_if.slave (control, digit and result signals)
// ----------------------------------------------------------------------------
module radix_4_quot_otfc #(
   parameter int QUOT_W = 32,
   parameter int ITER_N = QUOT_W / 2
) (
   input  logic                  clk,
   input  logic                  rst,
   radix_4_quot_otfc_if.slave    bus
);

   localparam int               CNT_W    = $clog2(ITER_N + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [QUOT_W-1:0]   q_q, q_d;
   logic [QUOT_W-1:0]   qm_q, qm_d;
   logic                err_q, err_d;
   logic                dig_acc;

   // start_i and flush_i both pre-empt a digit arriving in the same cycle.
   assign dig_acc = (state_q == ITER) && bus.dig_vld_i && !bus.start_i && !bus.flush_i;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      if (bus.start_i) begin
         state_d = ITER;
      end else if (bus.flush_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            ITER:    if (dig_acc && (cnt_q == LAST_CNT)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------- output logic (decoded from registers only) ----------------
   always_comb begin
      bus.busy_o    = (state_q == ITER);
      bus.done_o    = (state_q == DONE);
      bus.quot_o    = q_q;
      bus.quot_m1_o = qm_q;
      bus.dig_err_o = err_q;
   end

   // ---------------- datapath next-state ----------------
   always_comb begin
      q_d   = q_q;
      qm_d  = qm_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (bus.start_i) begin
         q_d   = '0;
         qm_d  = '1;
         cnt_d = '0;
         err_d = 1'b0;
      end else if (bus.flush_i) begin
         cnt_d = '0;
      end else if (dig_acc) begin
         cnt_d = cnt_q + 1'b1;
         case (bus.quot_dig_i)
            5'b10000: begin   // +2
               q_d  = {q_q[QUOT_W-3:0], 2'b10};
               qm_d = {q_q[QUOT_W-3:0], 2'b01};
            end
            5'b01000: begin   // +1
               q_d  = {q_q[QUOT_W-3:0], 2'b01};
               qm_d = {q_q[QUOT_W-3:0], 2'b00};
            end
            5'b00100: begin   // 0
               q_d  = {q_q[QUOT_W-3:0], 2'b00};
               qm_d = {qm_q[QUOT_W-3:0], 2'b11};
            end
            5'b00010: begin   // -1
               q_d  = {qm_q[QUOT_W-3:0], 2'b11};
               qm_d = {qm_q[QUOT_W-3:0], 2'b10};
            end
            5'b00001: begin   // -2
               q_d  = {qm_q[QUOT_W-3:0], 2'b10};
               qm_d = {qm_q[QUOT_W-3:0], 2'b01};
            end
            default: begin    // not one-hot: absorb as digit 0 and flag it
               q_d   = {q_q[QUOT_W-3:0], 2'b00};
               qm_d  = {qm_q[QUOT_W-3:0], 2'b11};
               err_d = 1'b1;
            end
         endcase
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q   <= '0;
         qm_q  <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         qm_q  <= qm_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_radix_4_quot_otfc.sv
// ----------------------------------------------------------------------------
// tb_radix_4_quot_otfc
// Bench for the radix-4 on-the-fly quotient converter (QUOT_W=8, ITER_N=4).
// The reference model treats the quotient as a plain integer: each digit d
// gives q = (4*q + d) mod 256 and qm = q - 1 mod 256; non-one-hot codes count
// as digit 0 and set the error flag. Expected results go into a queue that a
// separate monitor pops whenever done_o is seen.
// ----------------------------------------------------------------------------
module tb_radix_4_quot_otfc;

   localparam int QUOT_W = 8;
   localparam int ITER_N = 4;
   localparam int MASK   = (1 << QUOT_W) - 1;

   typedef struct packed {
      logic [QUOT_W-1:0] q;
      logic [QUOT_W-1:0] qm;
      logic              err;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb[$];
   int   n_checks;
   int   n_errors;
   int   d_a[ITER_N];
   int   s_a[ITER_N];

   radix_4_quot_otfc_if #(.QUOT_W(QUOT_W)) bus ();

   radix_4_quot_otfc #(.QUOT_W(QUOT_W), .ITER_N(ITER_N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Digits -2..+2 map to their one-hot code; 97/98/99 select illegal codes.
   function automatic logic [4:0] enc(input int d);
      logic [4:0] code;
      if (d >= -2 && d <= 2) begin
         code = 5'b00001;
         code = code << (d + 2);
      end else if (d == 97) begin
         code = 5'b11111;
      end else if (d == 98) begin
         code = 5'b00000;
      end else begin
         code = 5'b01100;
      end
      return code;
   endfunction

   function automatic bit legal(input int d);
      return (d >= -2 && d <= 2);
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done_o === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done_o=1, required no done (nothing pending)");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_quot", 32'(bus.quot_o), 32'(e.q));
            check("sb_quot_m1", 32'(bus.quot_m1_o), 32'(e.qm));
            check("sb_dig_err", 32'(bus.dig_err_o), 32'(e.err));
         end
      end
   end

   // One division: start (with a competing digit and maybe flush), digits with
   // optional stalls before each, optional flush before digit flush_after.
   task automatic run_div(input int flush_after, input int exp_q, input int exp_qm);
      int   q;
      bit   err;
      exp_t e;
      bus.start_i    = 1'b1;
      bus.flush_i    = 1'($urandom_range(0, 1));
      bus.dig_vld_i  = 1'b1;
      bus.quot_dig_i = enc(int'($urandom_range(0, 4)) - 2);
      cyc();
      bus.start_i   = 1'b0;
      bus.flush_i   = 1'b0;
      bus.dig_vld_i = 1'b0;
      check("start_quot", 32'(bus.quot_o), 32'h0);
      check("start_quot_m1", 32'(bus.quot_m1_o), 32'(MASK));
      check("start_busy", 32'(bus.busy_o), 32'h1);
      check("start_err", 32'(bus.dig_err_o), 32'h0);
      q   = 0;
      err = 1'b0;
      for (int i = 0; i < ITER_N; i++) begin
         for (int s = 0; s < s_a[i]; s++) begin
            bus.quot_dig_i = 5'($urandom);
            cyc();
            check("stall_busy", 32'(bus.busy_o), 32'h1);
            check("stall_done", 32'(bus.done_o), 32'h0);
         end
         if (i == flush_after) begin
            bus.flush_i    = 1'b1;
            bus.dig_vld_i  = 1'b1;
            bus.quot_dig_i = enc(2);
            cyc();
            bus.flush_i   = 1'b0;
            bus.dig_vld_i = 1'b0;
            check("flush_busy", 32'(bus.busy_o), 32'h0);
            check("flush_quot_hold", 32'(bus.quot_o), 32'(q & MASK));
            check("flush_quot_m1_hold", 32'(bus.quot_m1_o), 32'((q - 1) & MASK));
            for (int k = 0; k < 3; k++) begin
               cyc();
               check("flush_no_done", 32'(bus.done_o), 32'h0);
            end
            return;
         end
         bus.dig_vld_i  = 1'b1;
         bus.quot_dig_i = enc(d_a[i]);
         if (legal(d_a[i])) q = (4 * q + d_a[i]) & MASK;
         else begin
            q   = (4 * q) & MASK;
            err = 1'b1;
         end
         if (i == ITER_N - 1) begin
            e.q  = QUOT_W'(q);
            e.qm = QUOT_W'((q - 1) & MASK);
            e.err = err;
            sb.push_back(e);
         end
         cyc();
         bus.dig_vld_i = 1'b0;
         if (!legal(d_a[i])) check("dig_err_set", 32'(bus.dig_err_o), 32'h1);
         if (i < ITER_N - 1) begin
            check("iter_busy", 32'(bus.busy_o), 32'h1);
            check("iter_no_done", 32'(bus.done_o), 32'h0);
         end
      end
      // Last digit absorbed: done must be up now, exactly one cycle.
      check("done_pulse", 32'(bus.done_o), 32'h1);
      check("done_busy", 32'(bus.busy_o), 32'h0);
      if (exp_q >= 0) begin
         check("spec_quot", 32'(bus.quot_o), 32'(exp_q));
         check("spec_quot_m1", 32'(bus.quot_m1_o), 32'(exp_qm));
      end
      cyc();
      check("done_one_cycle", 32'(bus.done_o), 32'h0);
      check("idle_busy", 32'(bus.busy_o), 32'h0);
      // Digits outside ITER must be ignored; results hold.
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
         bus.dig_vld_i  = 1'b1;
         bus.quot_dig_i = enc(2);
         cyc();
      end
      bus.dig_vld_i = 1'b0;
      check("hold_quot", 32'(bus.quot_o), 32'(q & MASK));
      check("hold_quot_m1", 32'(bus.quot_m1_o), 32'((q - 1) & MASK));
   endtask

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      rst            = 1'b1;
      bus.start_i    = 1'b0;
      bus.flush_i    = 1'b0;
      bus.dig_vld_i  = 1'b0;
      bus.quot_dig_i = 5'b00100;
      cyc();
      cyc();
      check("rst_busy", 32'(bus.busy_o), 32'h0);
      check("rst_done", 32'(bus.done_o), 32'h0);
      check("rst_quot", 32'(bus.quot_o), 32'h0);
      check("rst_quot_m1", 32'(bus.quot_m1_o), 32'h0);
      check("rst_err", 32'(bus.dig_err_o), 32'h0);
      rst = 1'b0;
      cyc();

      // 1: +2,+1,0,-1 back to back
      d_a = '{2, 1, 0, -1};   s_a = '{0, 0, 0, 0};
      run_div(-1, 'h8F, 'h8E);
      // 2: four -2, two stall cycles before the 3rd digit
      d_a = '{-2, -2, -2, -2}; s_a = '{0, 0, 2, 0};
      run_div(-1, 'h56, 'h55);
      // 3: four +2
      d_a = '{2, 2, 2, 2};    s_a = '{0, 0, 0, 0};
      run_div(-1, 'hAA, 'hA9);
      // 4: flush after two digits, then four zeros
      d_a = '{1, -1, 2, 2};   s_a = '{0, 0, 0, 0};
      run_div(2, -1, -1);
      d_a = '{0, 0, 0, 0};
      run_div(-1, 'h00, 'hFF);
      // 5: illegal 5'b01100 mid-run
      d_a = '{1, 99, -1, 2};
      run_div(-1, -1, -1);

      // 6: reset in the middle of ITER after an illegal digit
      bus.start_i = 1'b1;
      cyc();
      bus.start_i    = 1'b0;
      bus.dig_vld_i  = 1'b1;
      bus.quot_dig_i = enc(1);
      cyc();
      bus.quot_dig_i = enc(99);
      cyc();
      bus.dig_vld_i = 1'b0;
      rst = 1'b1;
      cyc();
      check("midrst_busy", 32'(bus.busy_o), 32'h0);
      check("midrst_done", 32'(bus.done_o), 32'h0);
      check("midrst_quot", 32'(bus.quot_o), 32'h0);
      check("midrst_quot_m1", 32'(bus.quot_m1_o), 32'h0);
      check("midrst_err", 32'(bus.dig_err_o), 32'h0);
      rst = 1'b0;
      cyc();
      d_a = '{-1, 0, 1, 2};   s_a = '{0, 0, 0, 0};
      run_div(-1, -1, -1);

      // Randomized divisions
      for (int r = 0; r < 40; r++) begin
         int fa;
         for (int i = 0; i < ITER_N; i++) begin
            int v;
            v = int'($urandom_range(0, 12));
            d_a[i] = (v < 10) ? (v % 5) - 2 : 87 + v;
            s_a[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         end
         fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, ITER_N - 1)) : -1;
         run_div(fa, -1, -1);
      end

      cyc();
      cyc();
      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
